// File: rtl/serial_pattern_gen.sv
// Serial stimulus source: plays a loaded bit pattern LSB first on `a`, one bit per clock,
// with optional looping, early stop and a one-cycle done pulse after a non-looping pass.
module serial_pattern_gen #(
  parameter int W  = 16,
  parameter int LW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [W-1:0]  pattern,
  input  logic [LW-1:0] len,
  input  logic          start,
  input  logic          loop,
  input  logic          stop,
  output logic          a,
  output logic          a_valid,
  output logic          busy,
  output logic          done,
  output logic [LW-1:0] bit_cnt
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADED = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t        state_reg;
  logic [W-1:0]  pat_reg;
  logic [LW-1:0] len_reg;
  logic          loop_reg;
  logic [LW-1:0] len_clamped;
  logic          load_ok;

  always_comb begin
    len_clamped = (len > LW'(W)) ? LW'(W) : len;
    load_ok     = load && (len != '0);
  end

  // bit_cnt doubles as the index of the next bit to send: it counts bits already
  // emitted, so pat_reg[bit_cnt] is the following one and the pattern is never shifted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      pat_reg   <= '0;
      len_reg   <= '0;
      loop_reg  <= 1'b0;
      a         <= 1'b0;
      a_valid   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bit_cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE, LOADED, DONE: begin
          if (load_ok) begin
            pat_reg   <= pattern;
            len_reg   <= len_clamped;
            state_reg <= LOADED;
          end else if (state_reg == DONE) begin
            state_reg <= LOADED;
          end else if (state_reg == LOADED && start && !load) begin
            state_reg <= RUN;
            loop_reg  <= loop;
            a         <= pat_reg[0];
            a_valid   <= 1'b1;
            busy      <= 1'b1;
            bit_cnt   <= LW'(1);
          end
        end
        RUN: begin
          if (stop) begin
            state_reg <= LOADED;
            a         <= 1'b0;
            a_valid   <= 1'b0;
            busy      <= 1'b0;
            bit_cnt   <= '0;
          end else if (bit_cnt == len_reg) begin
            if (loop_reg) begin
              a       <= pat_reg[0];
              bit_cnt <= LW'(1);
            end else begin
              state_reg <= DONE;
              a         <= 1'b0;
              a_valid   <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              bit_cnt   <= '0;
            end
          end else begin
            a       <= pat_reg[bit_cnt[IW-1:0]];
            bit_cnt <= bit_cnt + LW'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Bench for serial_pattern_gen: directed scenarios plus random traffic, every cycle
// compared against a queue-based playback model.
module tb_serial_pattern_gen;

  logic        clk = 1'b0;
  logic        rst, load, start, loop, stop;
  logic [15:0] pattern;
  logic [4:0]  len;
  logic        a, a_valid, busy, done;
  logic [4:0]  bit_cnt;

  int checks = 0;
  int errors = 0;

  serial_pattern_gen #(.W(16), .LW(5)) dut (
    .clk(clk), .rst(rst), .load(load), .pattern(pattern), .len(len),
    .start(start), .loop(loop), .stop(stop),
    .a(a), .a_valid(a_valid), .busy(busy), .done(done), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: a mode plus a queue of bits still to be sent in the current pass.
  localparam int M_EMPTY = 0, M_READY = 1, M_PLAY = 2, M_FIN = 3;
  int          m_mode = M_EMPTY;
  logic [15:0] m_pat  = '0;
  int          m_len  = 0;
  bit          m_loop = 1'b0;
  bit          m_q[$];
  bit          m_cur  = 1'b0;

  function automatic void refill();
    m_q.delete();
    for (int i = 0; i < m_len; i++) m_q.push_back(m_pat[i]);
  endfunction

  task automatic model_step();
    if (rst) begin
      m_mode = M_EMPTY; m_pat = '0; m_len = 0; m_q.delete();
    end else if (m_mode == M_PLAY) begin
      if (stop) begin
        m_mode = M_READY; m_q.delete();
      end else if (m_q.size() == 0) begin
        if (m_loop) begin refill(); m_cur = m_q.pop_front(); end
        else m_mode = M_FIN;
      end else begin
        m_cur = m_q.pop_front();
      end
    end else if (load && len != 0) begin
      m_pat = pattern; m_len = (len > 16) ? 16 : int'(len); m_mode = M_READY;
    end else if (m_mode == M_FIN) begin
      m_mode = M_READY;
    end else if (m_mode == M_READY && start && !load) begin
      m_mode = M_PLAY; m_loop = loop; refill(); m_cur = m_q.pop_front();
    end
  endtask

  task automatic cycle();
    bit play;
    @(posedge clk);
    model_step();
    #1;
    play = (m_mode == M_PLAY);
    check("a",       a,       play ? m_cur : 1'b0);
    check("a_valid", a_valid, play);
    check("busy",    busy,    play);
    check("done",    done,    m_mode == M_FIN);
    check("bit_cnt", bit_cnt, play ? (m_len - m_q.size()) : 0);
  endtask

  task automatic drive(input bit r, input bit l, input logic [15:0] p, input logic [4:0] n,
                       input bit s, input bit lp, input bit sp);
    rst = r; load = l; pattern = p; len = n; start = s; loop = lp; stop = sp;
    if (r)  $display("txn rst");
    if (l)  $display("txn load pattern=%h len=%0d", p, n);
    if (s)  $display("txn start loop=%0b", lp);
    if (sp) $display("txn stop");
    cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 16'h0, 5'd0, 0, 0, 0);
  endtask

  logic [8:0]  seq9;
  logic [9:0]  seq10;

  initial begin
    rst = 1; load = 0; pattern = '0; len = '0; start = 0; loop = 0; stop = 0;
    cycle();

    // Non-looping 9-bit pass
    drive(0, 1, 16'h0174, 5'd9, 0, 0, 0);
    drive(0, 0, 16'h0, 5'd0, 1, 0, 0);
    seq9[0] = a;
    for (int i = 1; i < 9; i++) begin idle(1); seq9[i] = a; end
    check("t1_seq", seq9, 9'h174);
    idle(1);
    check("t1_done", done, 1'b1);
    idle(1);

    // Looping 3-bit pattern, then stop and restart
    drive(0, 1, 16'h0005, 5'd3, 0, 0, 0);
    drive(0, 0, 16'h0, 5'd0, 1, 1, 0);
    seq10[0] = a;
    for (int i = 1; i < 10; i++) begin idle(1); seq10[i] = a; end
    check("t2_seq", seq10, 10'h36D);
    drive(0, 0, 16'h0, 5'd0, 0, 0, 1);
    idle(1);
    drive(0, 0, 16'h0, 5'd0, 1, 0, 0);
    check("t2_restart", a, 1'b1);
    idle(4);

    // Load during RUN ignored; load+start together captures only
    drive(0, 1, 16'h0174, 5'd9, 0, 0, 0);
    drive(0, 0, 16'h0, 5'd0, 1, 0, 0);
    idle(2);
    drive(0, 1, 16'hFFFF, 5'd16, 0, 0, 0);
    idle(8);
    drive(0, 1, 16'hFFFF, 5'd16, 1, 0, 0);
    check("t3_ldst_busy", busy, 1'b0);
    drive(0, 0, 16'h0, 5'd0, 1, 0, 0);
    idle(17);

    // len=0 rejected in IDLE; len=20 clamps to 16
    drive(1, 0, 16'h0, 5'd0, 0, 0, 0);
    drive(0, 1, 16'h1234, 5'd0, 0, 0, 0);
    drive(0, 0, 16'h0, 5'd0, 1, 0, 0);
    check("t4_len0_busy", busy, 1'b0);
    drive(0, 1, 16'hA5C3, 5'd20, 0, 0, 0);
    drive(0, 0, 16'h0, 5'd0, 1, 0, 0);
    idle(15);
    check("t4_last_cnt", bit_cnt, 5'd16);
    idle(2);

    // Reset mid-playback
    drive(0, 1, 16'h0174, 5'd9, 0, 0, 0);
    drive(0, 0, 16'h0, 5'd0, 1, 0, 0);
    idle(3);
    drive(1, 0, 16'h0, 5'd0, 0, 0, 0);
    drive(0, 0, 16'h0, 5'd0, 1, 0, 0);
    check("t5_idle_start", busy, 1'b0);

    // len=1, non-looping and looping
    drive(0, 1, 16'h0001, 5'd1, 0, 0, 0);
    drive(0, 0, 16'h0, 5'd0, 1, 0, 0);
    idle(2);
    drive(0, 0, 16'h0, 5'd0, 1, 1, 0);
    idle(5);
    check("t6_loop_cnt", bit_cnt, 5'd1);
    drive(0, 0, 16'h0, 5'd0, 0, 0, 1);
    idle(1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 63) == 0,
            $urandom_range(0, 9) == 0,
            16'($urandom()),
            5'($urandom_range(0, 20)),
            $urandom_range(0, 5) == 0,
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 15) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
